// File: rtl/hcp_pkg.sv
// Shared constants and types for the HCP bus master.
package hcp_pkg;

   localparam logic [7:0] FRAME_START_UID = 8'h7E;
   localparam logic [7:0] FRAME_START_GID = 8'h3E;
   localparam logic [7:0] FRAME_STOP      = 8'hFE;

   typedef enum logic [3:0] {
      IDLE,
      START_F,
      ADDR,
      ACK1,
      ACK2,
      LOAD,
      DATA,
      DACK,
      STOP_F
   } hcp_state_e;

   typedef enum logic [1:0] {
      STAT_OK         = 2'd0,
      STAT_NACK_ADDR  = 2'd1,
      STAT_SLAVE_BUSY = 2'd2,
      STAT_NACK_DATA  = 2'd3
   } hcp_status_e;

   // States in which the master owns the line and shifts out a frame bit.
   function automatic logic is_drive_state(input hcp_state_e s);
      return (s == START_F) || (s == ADDR) || (s == DATA) || (s == STOP_F);
   endfunction

endpackage

// File: rtl/hcp_clkgen.sv
// Bus clock generator: one slot = CLK_DIV cycles low then CLK_DIV cycles high.
module hcp_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic hcp_clk,
   output logic slot_start,
   output logic slot_sample
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          half;

   // Divider and half-slot phase; parked at the start of a slot while not running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         half    <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         half    <= 1'b0;
      end else if (div_cnt == DIV_MAX) begin
         div_cnt <= '0;
         half    <= ~half;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // Gating with run drops the bus clock in the same cycle the master parks.
   assign hcp_clk     = run & half;
   assign slot_start  = run & ~half & (div_cnt == '0);
   assign slot_sample = run &  half & (div_cnt == DIV_MAX);

endmodule

// File: rtl/hcp_master.sv
// HCP bus master: serialises start/address/ACK/payload/stop onto sbda.
module hcp_master
   import hcp_pkg::*;
#(
   parameter int         CLK_DIV    = 4,
   parameter logic [7:0] START_UID  = FRAME_START_UID,
   parameter logic [7:0] START_GID  = FRAME_START_GID,
   parameter logic [7:0] STOP_FRAME = FRAME_STOP
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gid_mode,
   input  logic [7:0] addr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   output logic       hcp_clk,
   output logic       sbda_o,
   output logic       sbda_oe,
   input  logic       sbda_i
);

   hcp_state_e  state_q, state_d;
   hcp_status_e status_q, status_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        done_q, done_d;
   logic        line_hold_q;
   logic        accept, take_byte;

   logic [7:0]  addr_q, byte_q;
   logic        gid_q, last_q;

   logic        run, slot_start, slot_sample, drive;
   logic [7:0]  frame_byte;

   // The bus clock only runs while a slot is in progress; LOAD stretches the bus.
   assign run = (state_q != IDLE) && (state_q != LOAD);

   hcp_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .hcp_clk     (hcp_clk),
      .slot_start  (slot_start),
      .slot_sample (slot_sample)
   );

   // Byte currently being shifted out, selected by the frame being sent.
   always_comb begin
      frame_byte = STOP_FRAME;
      case (state_q)
         START_F: frame_byte = gid_q ? START_GID : START_UID;
         ADDR:    frame_byte = addr_q;
         DATA:    frame_byte = byte_q;
         default: frame_byte = STOP_FRAME;
      endcase
   end

   assign drive   = is_drive_state(state_q);
   assign sbda_oe = drive;
   assign sbda_o  = drive ? frame_byte[bit_cnt_q] : line_hold_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign status  = status_q;

   // Next-state, bit counter, status and handshake decisions.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      status_d  = status_q;
      done_d    = 1'b0;
      tx_ready  = 1'b0;
      accept    = 1'b0;
      take_byte = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = START_F;
               bit_cnt_d = 3'd0;
               status_d  = STAT_OK;
               accept    = 1'b1;
            end
         end
         START_F, ADDR, DATA: begin
            if (slot_sample) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  case (state_q)
                     START_F: state_d = ADDR;
                     ADDR:    state_d = ACK1;
                     default: state_d = DACK;
                  endcase
               end
            end
         end
         ACK1: begin
            if (slot_sample) begin
               if (sbda_i) begin
                  status_d = STAT_NACK_ADDR;
                  state_d  = STOP_F;
               end else begin
                  state_d  = ACK2;
               end
            end
         end
         ACK2: begin
            if (slot_sample) begin
               if (sbda_i) begin
                  status_d = STAT_SLAVE_BUSY;
                  state_d  = STOP_F;
               end else begin
                  state_d  = LOAD;
               end
            end
         end
         LOAD: begin
            if (tx_valid) begin
               tx_ready  = 1'b1;
               take_byte = 1'b1;
               state_d   = DATA;
            end
         end
         DACK: begin
            if (slot_sample) begin
               if (sbda_i) begin
                  status_d = STAT_NACK_DATA;
                  state_d  = STOP_F;
               end else if (gid_q || last_q) begin
                  state_d  = STOP_F;
               end else begin
                  state_d  = LOAD;
               end
            end
         end
         STOP_F: begin
            if (slot_sample) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         status_q    <= STAT_OK;
         bit_cnt_q   <= 3'd0;
         done_q      <= 1'b0;
         line_hold_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         status_q  <= status_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         if (slot_start && drive) begin
            line_hold_q <= frame_byte[bit_cnt_q];
         end
      end
   end

   // Transaction parameters and payload byte, captured at start and handshake.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= addr;
         gid_q  <= gid_mode;
      end
      if (take_byte) begin
         byte_q <= tx_data;
         last_q <= tx_last;
      end
   end

endmodule

// File: tb/tb_hcp_master.sv
// Randomised bench for hcp_master with a slot-level slave and transaction model.
module tb_hcp_master;

   localparam int CLK_DIV = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       gid_mode = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, busy, done, hcp_clk, sbda_o, sbda_oe, sbda_i;
   logic [1:0] status;

   hcp_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .gid_mode (gid_mode),
      .addr     (addr),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done),
      .status   (status),
      .hcp_clk  (hcp_clk),
      .sbda_o   (sbda_o),
      .sbda_oe  (sbda_oe),
      .sbda_i   (sbda_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural slave: responds to the ACK slots by slot index in the transaction.
   int rise_cnt = 0;
   int base     = 0;
   int ack1_v   = 0;
   int ack2_v   = 0;
   int nack_idx = -1;
   logic obs_mem [0:4095];
   logic slave_drv;
   int   slot_idx;
   logic [7:0] payload [0:7];

   function automatic logic slave_resp(input int s, input int a1, input int a2, input int nk);
      if (s == 16) return a1[0];
      if (s == 17) return a2[0];
      if (s >= 18 && ((s - 18) % 9) == 8) return ((s - 18) / 9 == nk);
      return 1'b1;
   endfunction

   always_comb begin
      slot_idx  = (hcp_clk ? rise_cnt - 1 : rise_cnt) - base;
      slave_drv = slave_resp(slot_idx, ack1_v, ack2_v, nack_idx);
   end

   assign sbda_i = sbda_oe ? sbda_o : slave_drv;

   // Line monitor: every hcp_clk rise is one bus bit as a slave sees it.
   always @(posedge hcp_clk) begin
      obs_mem[rise_cnt % 4096] = sbda_oe ? sbda_o : slave_resp(rise_cnt - base, ack1_v, ack2_v, nack_idx);
      rise_cnt = rise_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One transaction: drive host side, then compare against the frame model.
   task automatic run_txn(input bit gid, input logic [7:0] a, input int n_in, input int stall,
                          input int a1, input int a2, input int nk, input bit early_in);
      int fw[$];
      int fv[$];
      int n, exp_slots, exp_loads, exp_status, exp_cycles;
      int cyc, i, stall_cnt, ready_cnt, pos, done_seen_busy;
      bit got_done, in_load, early;
      logic [31:0] val;
      n = gid ? 1 : n_in;
      early = early_in && (stall == 0);
      exp_loads = 0;
      exp_status = 0;
      fw.push_back(8); fv.push_back(gid ? 8'h3E : 8'h7E);
      fw.push_back(8); fv.push_back(a);
      fw.push_back(1); fv.push_back(a1);
      if (a1 != 0) exp_status = 1;
      else begin
         fw.push_back(1); fv.push_back(a2);
         if (a2 != 0) exp_status = 2;
         else begin
            for (int k = 0; k < n; k++) begin
               exp_loads++;
               fw.push_back(8); fv.push_back(payload[k]);
               fw.push_back(1); fv.push_back(k == nk ? 1 : 0);
               if (k == nk) begin
                  exp_status = 3;
                  break;
               end
            end
         end
      end
      fw.push_back(8); fv.push_back(8'hFE);
      exp_slots = 0;
      foreach (fw[k]) exp_slots += fw[k];
      exp_cycles = exp_slots * 2 * CLK_DIV + exp_loads * (1 + stall);

      ack1_v = a1; ack2_v = a2; nack_idx = nk;
      base = rise_cnt;
      start = 1'b1; gid_mode = gid; addr = a; tx_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", busy, 1);
      cyc = 0; i = 0; stall_cnt = 0; ready_cnt = 0; got_done = 0; done_seen_busy = 0;
      while (cyc < 4000) begin
         if (done) begin
            got_done = 1;
            done_seen_busy = busy;
            break;
         end
         if (cyc == 20) begin
            start = 1'b1; addr = ~a; gid_mode = ~gid;
         end else if (cyc == 21) begin
            start = 1'b0; addr = a; gid_mode = gid;
         end
         in_load = busy && !hcp_clk && !sbda_oe && (i < n) && (rise_cnt - base == 18 + 9 * i);
         if (in_load) begin
            if (stall_cnt >= stall) tx_valid = 1'b1;
            else begin
               stall_cnt++;
               tx_valid = 1'b0;
            end
         end else begin
            tx_valid = early && (i < n);
         end
         tx_data = payload[(i < n) ? i : 0];
         tx_last = gid ? 1'($urandom_range(0, 1)) : (i == n - 1);
         #1;
         if (tx_ready) begin
            ready_cnt++;
            if (tx_valid) begin
               i++;
               stall_cnt = 0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      tx_valid = 1'b0;
      chk("done_seen", got_done, 1);
      chk("txn_cycles", cyc, exp_cycles);
      chk("busy_at_done", done_seen_busy, 0);
      chk("status", status, exp_status);
      chk("ready_pulses", ready_cnt, exp_loads);
      chk("slot_count", rise_cnt - base, exp_slots);
      pos = base;
      foreach (fw[k]) begin
         val = '0;
         for (int b = 0; b < fw[k]; b++) val[b] = obs_mem[(pos + b) % 4096];
         pos += fw[k];
         chk($sformatf("field%0d", k), val, fv[k]);
      end
   endtask

   task automatic idle_check(input int cycles);
      int bad;
      bad = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (hcp_clk !== 1'b0 || sbda_oe !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("idle_quiet", bad, 0);
   endtask

   initial begin
      int found;
      @(negedge clk);
      chk("rst_hcp_clk", hcp_clk, 0);
      chk("rst_sbda_oe", sbda_oe, 0);
      chk("rst_sbda_o", sbda_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_status", status, 0);
      rst_n = 1'b1;
      @(negedge clk);

      payload[0] = 8'h55; payload[1] = 8'hA3;
      run_txn(0, 8'hAC, 2, 0, 0, 0, -1, 0);
      idle_check(6);
      run_txn(0, 8'h12, 1, 0, 1, 0, -1, 1);
      run_txn(0, 8'h34, 1, 0, 0, 1, -1, 1);
      payload[0] = 8'h5B;
      run_txn(1, 8'hAC, 1, 0, 0, 0, -1, 1);
      payload[0] = 8'hC7; payload[1] = 8'h19;
      run_txn(0, 8'h6D, 2, 40, 0, 0, 0, 0);
      idle_check(4);

      // Asynchronous reset during address bit 3, then a clean frame.
      start = 1'b1; gid_mode = 1'b0; addr = 8'hC3;
      base = rise_cnt;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 300; c++) begin
         if (rise_cnt - base == 11 && !hcp_clk) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("reach_addr_bit3", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_hcp_clk", hcp_clk, 0);
      chk("mid_rst_sbda_oe", sbda_oe, 0);
      chk("mid_rst_sbda_o", sbda_o, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_tx_ready", tx_ready, 0);
      chk("mid_rst_status", status, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      payload[0] = 8'h0F; payload[1] = 8'hF0; payload[2] = 8'h81;
      run_txn(0, 8'hC3, 3, 0, 0, 0, -1, 1);

      for (int t = 0; t < 14; t++) begin
         bit g, e;
         int n, a1, a2, nk, st;
         g  = ($urandom % 4) == 0;
         n  = $urandom_range(1, 4);
         a1 = (($urandom % 8) == 0) ? 1 : 0;
         a2 = (($urandom % 8) == 0) ? 1 : 0;
         nk = (($urandom % 4) == 0) ? $urandom_range(0, n - 1) : -1;
         st = (($urandom % 3) == 0) ? $urandom_range(1, 6) : 0;
         e  = 1'($urandom % 2);
         for (int k = 0; k < 4; k++) begin
            payload[k] = 8'($urandom);
            if (payload[k] == 8'hFE) payload[k] = 8'h01;
         end
         run_txn(g, 8'($urandom), n, st, a1, a2, nk, e);
      end
      idle_check(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
